// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for the bit-serial
//               adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  // Default operand width; legal range 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit full-adder cell used as the datapath bit-slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic cout
);

  // Plain sum / majority-carry logic.
  always_comb begin
    sum  = A ^ B ^ Cin;
    cout = (A & B) | (A & Cin) | (B & Cin);
  end

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor. One full-adder cell processes
//               the operands LSB first, one bit per clock, with a registered
//               carry. Start/busy/done handshake; results held until the
//               next operation completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             carry_q,   carry_d;
  logic             cout_q,    cout_d;
  logic             msb_cin_q, msb_cin_d;

  logic fa_sum;
  logic fa_cout;

  // Single bit-slice shared by every bit position.
  full_adder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State, datapath and result registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      msb_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      msb_cin_q <= msb_cin_d;
    end
  end

  // Next-state and datapath control; DONE accepts a new request like IDLE.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    count_d   = count_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    msb_cin_d = msb_cin_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1; Cin is ignored in that mode.
          a_sh_d  = A;
          b_sh_d  = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST_BIT) begin
          // Final bit: publish the result and keep the carry into the MSB
          // so overflow can be formed from the two registered carries.
          sum_d     = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_d    = fa_cout;
          msb_cin_d = carry_q;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = msb_cin_q ^ cout_q;

endmodule : serial_adder

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands, one bit per clock, LSB first.
- Uses a single one-bit full-adder cell with a registered carry.
- Start/busy/done handshake; result and flags are held until the next operation.
- Sits in the lab datapath as the area-cheap successor to the one-shot combinational adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = A+B+Cin, 1 = A-B (B inverted, carry-in forced 1, Cin ignored)
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- Cin  input  1  carry-in for add mode, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result, valid from the done pulse until the next accepted start
- cout  output  1  carry out of MSB; in sub mode, 1 = no borrow
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous, active-high, and dominates all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, count=0, carry=0, operand shift registers=0.
- States:
  - IDLE: waiting for a request.
  - RUN: processing bits.
  - DONE: one-cycle result-valid state.
- IDLE, on start=1:
  - Load a_sh=A.
  - Load b_sh = sub ? ~B : B.
  - Load carry = sub ? 1 : Cin.
  - Set count=0 and go to RUN.
- RUN, each cycle:
  - Full adder on (a_sh[0], b_sh[0], carry).
  - Sum bit shifts into sum_sh from the MSB side; a_sh and b_sh shift right; carry <= cell cout; count++.
  - On the edge where count == WIDTH-1, capture:
    - carry-into-MSB (the carry before the final bit) into a msb_cin register.
    - the final cout.
  - Then go to DONE.
- DONE, lasting exactly 1 cycle:
  - done=1.
  - sum, cout and ovf outputs update on entry to DONE.
  - Next state is IDLE. If start=1 during DONE, the request is accepted as in IDLE and the next state is RUN; done still pulses only once.
- Latency: start sampled at edge k → done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- busy: high in RUN, low in IDLE and DONE.
- start while busy is ignored. Operands are not re-sampled and there is no queueing.
- A, B, Cin and sub may change freely after acceptance; the captured copies are used.
- sum, cout and ovf hold their last values in IDLE and while a new RUN is in progress. They change only on entry to DONE or on reset.
- Wrap-around: the sum is modulo 2^WIDTH; the overflowed bit appears only in cout.
- Reset mid-RUN: everything returns to reset values on the next edge, no done pulse is generated, and a subsequent start behaves normally.
- start and rst high together: reset wins and the request is lost.

Decomposition:
- Package serial_adder_pkg:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH default constant.
- Sub-module: the existing team full_adder cell (ports A, B, Cin, sum, cout), instantiated once as the bit-slice. The top holds the FSM, counter, shift registers and flag logic.
- No other sub-modules.

Test Plan:
- WIDTH=8, sub=0, A=8'hFF, B=8'h01, Cin=0 → sum=8'h00, cout=1, ovf=0; done pulses exactly 8 cycles after start, width 1; busy high 8 cycles.
- WIDTH=8, sub=0, A=8'h7F, B=8'h01, Cin=0 → sum=8'h80, cout=0, ovf=1. Then A=8'h10, B=8'h20, Cin=1 → sum=8'h31, cout=0, ovf=0.
- WIDTH=8, sub=1, A=8'h05, B=8'h07, Cin=1 (ignored) → sum=8'hFE, cout=0, ovf=0. Then A=8'h80, B=8'h01 → sum=8'h7F, cout=1, ovf=1.
- start pulsed again at cycle 3 of a RUN with different A/B → ignored; the original result is delivered. start held high through DONE → back-to-back op accepted; second done exactly 9 cycles after the first.
- rst asserted at cycle 4 of RUN → next cycle all outputs 0, state IDLE, no done. Fresh 8'h01+8'h01 then yields 8'h02.
- WIDTH=4 exhaustive sweep of all A, B, Cin, sub (1024 cases) against a behavioural model → all sum/cout/ovf match, one done per op.
